// File: rtl/bu_writeback.sv
`default_nettype none
// ============================================================================
// Module      : bu_writeback
// Description : NTT return-path router. Re-aligns the eight BU outputs to the
//               bank/port they were read from, delays the issue addresses to
//               match BU latency and tracks stage completion.
// Revision    : 1.0 - initial release
// ============================================================================
module bu_writeback #(
   parameter int DATA_WIDTH = 13,
   parameter int ADDR_WIDTH = 5,
   parameter int BU_LAT     = 3,
   parameter int GROUPS     = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          stage_start_i,
   input  logic [7:0]                    len_i,
   input  logic                          is_ntt_i,
   input  logic                          issue_valid_i,
   input  logic [ADDR_WIDTH-1:0]         issue_addr_a_i,
   input  logic [ADDR_WIDTH-1:0]         issue_addr_b_i,
   input  logic [8*(DATA_WIDTH-1)-1:0]   a_ntt_i,
   input  logic [8*(DATA_WIDTH-1)-1:0]   b_ntt_i,
   input  logic [8*(DATA_WIDTH-1)-1:0]   a_intt_i,
   input  logic [8*(DATA_WIDTH-1)-1:0]   b_intt_i,
   output logic                          wr_en_o,
   output logic [ADDR_WIDTH-1:0]         wr_addr_a_o,
   output logic [ADDR_WIDTH-1:0]         wr_addr_b_o,
   output logic [8*(DATA_WIDTH-1)-1:0]   wdata_a_o,
   output logic [8*(DATA_WIDTH-1)-1:0]   wdata_b_o,
   output logic                          busy_o,
   output logic                          stage_done_o,
   output logic                          err_o
);

   localparam int c_W  = DATA_WIDTH - 1;
   localparam int c_BW = 8 * c_W;
   localparam int c_CW = $clog2(GROUPS + 1);

   localparam logic [1:0] c_L128   = 2'd0;
   localparam logic [1:0] c_L64    = 2'd1;
   localparam logic [1:0] c_L32    = 2'd2;
   localparam logic [1:0] c_LSMALL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             len_cls_q, len_cls_d;
   logic                   is_ntt_q, is_ntt_d;
   logic [c_CW-1:0]        issue_cnt_q, issue_cnt_d;
   logic [c_CW-1:0]        wr_cnt_q, wr_cnt_d;
   logic                   err_q, err_d;
   logic                   busy_q, busy_d;
   logic                   stage_done_q, stage_done_d;

   logic                   tag_v_q [BU_LAT];
   logic                   tag_v_d [BU_LAT];
   logic [ADDR_WIDTH-1:0]  tag_a_q [BU_LAT];
   logic [ADDR_WIDTH-1:0]  tag_a_d [BU_LAT];
   logic [ADDR_WIDTH-1:0]  tag_b_q [BU_LAT];
   logic [ADDR_WIDTH-1:0]  tag_b_d [BU_LAT];

   logic                   wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]  wr_addr_a_q, wr_addr_a_d;
   logic [ADDR_WIDTH-1:0]  wr_addr_b_q, wr_addr_b_d;
   logic [c_BW-1:0]        wdata_a_q, wdata_a_d;
   logic [c_BW-1:0]        wdata_b_q, wdata_b_d;

   logic                   w_len_legal;
   logic [1:0]             w_len_cls;
   logic                   w_push;
   logic [c_W-1:0]         w_a_word [8];
   logic [c_W-1:0]         w_b_word [8];
   logic [c_BW-1:0]        w_route_a;
   logic [c_BW-1:0]        w_route_b;

   // Inverse read permutation: returns {take_b_output, bu_index} feeding
   // the given bank/port for the latched length class.
   function automatic logic [3:0] src_sel(input logic [1:0] cls,
                                          input logic [2:0] bank,
                                          input logic       port_b);
      logic [2:0] bu;
      logic       use_b;
      bu    = 3'd0;
      use_b = 1'b0;
      case (cls)
         c_L128: begin
            bu    = {bank[1:0], port_b};
            use_b = bank[2];
         end
         c_L64: begin
            bu    = {bank[2], port_b, bank[1]};
            use_b = bank[0];
         end
         c_L32: begin
            bu    = {bank[2:1], port_b};
            use_b = bank[0];
         end
         default: begin
            if (bank[2:1] == 2'b00) begin
               bu    = {2'b00, bank[0]};
               use_b = port_b;
            end else begin
               bu    = {bank[2:1], port_b};
               use_b = bank[0];
            end
         end
      endcase
      return {use_b, bu};
   endfunction

   always_comb begin
      w_len_legal = 1'b1;
      w_len_cls   = c_LSMALL;
      case (len_i)
         8'd128:                   w_len_cls = c_L128;
         8'd64:                    w_len_cls = c_L64;
         8'd32:                    w_len_cls = c_L32;
         8'd16, 8'd8, 8'd4, 8'd2:  w_len_cls = c_LSMALL;
         default:                  w_len_legal = 1'b0;
      endcase
   end

   for (genvar k = 0; k < 8; k++) begin : g_unpack
      assign w_a_word[k] = is_ntt_q ? a_ntt_i[k*c_W +: c_W] : a_intt_i[k*c_W +: c_W];
      assign w_b_word[k] = is_ntt_q ? b_ntt_i[k*c_W +: c_W] : b_intt_i[k*c_W +: c_W];
   end

   for (genvar j = 0; j < 8; j++) begin : g_bank
      logic [3:0] w_sel_a;
      logic [3:0] w_sel_b;
      assign w_sel_a = src_sel(len_cls_q, 3'(j), 1'b0);
      assign w_sel_b = src_sel(len_cls_q, 3'(j), 1'b1);
      assign w_route_a[j*c_W +: c_W] = w_sel_a[3] ? w_b_word[w_sel_a[2:0]]
                                                  : w_a_word[w_sel_a[2:0]];
      assign w_route_b[j*c_W +: c_W] = w_sel_b[3] ? w_b_word[w_sel_b[2:0]]
                                                  : w_a_word[w_sel_b[2:0]];
   end

   always_comb begin
      state_d     = state_q;
      len_cls_d   = len_cls_q;
      is_ntt_d    = is_ntt_q;
      issue_cnt_d = issue_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      err_d       = err_q;
      w_push      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (stage_start_i) begin
               if (w_len_legal) begin
                  len_cls_d   = w_len_cls;
                  is_ntt_d    = is_ntt_i;
                  issue_cnt_d = '0;
                  wr_cnt_d    = '0;
                  err_d       = 1'b0;
                  state_d     = ST_RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (issue_valid_i) err_d = 1'b1;
         end
         ST_RUN: begin
            if (stage_start_i) err_d = 1'b1;
            if (issue_valid_i) begin
               w_push      = 1'b1;
               issue_cnt_d = issue_cnt_q + c_CW'(1);
               if (issue_cnt_q == c_CW'(GROUPS - 1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (stage_start_i || issue_valid_i) err_d = 1'b1;
            if (wr_cnt_q == c_CW'(GROUPS)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (stage_start_i || issue_valid_i) err_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      tag_v_d[0] = w_push;
      tag_a_d[0] = issue_addr_a_i;
      tag_b_d[0] = issue_addr_b_i;
      for (int i = 1; i < BU_LAT; i++) begin
         tag_v_d[i] = tag_v_q[i-1];
         tag_a_d[i] = tag_a_q[i-1];
         tag_b_d[i] = tag_b_q[i-1];
      end

      // The tail tag and the BU results it belongs to arrive on the same edge.
      wr_en_d     = tag_v_q[BU_LAT-1];
      wr_addr_a_d = wr_en_d ? tag_a_q[BU_LAT-1] : wr_addr_a_q;
      wr_addr_b_d = wr_en_d ? tag_b_q[BU_LAT-1] : wr_addr_b_q;
      wdata_a_d   = wr_en_d ? w_route_a : wdata_a_q;
      wdata_b_d   = wr_en_d ? w_route_b : wdata_b_q;
      if (wr_en_d) wr_cnt_d = wr_cnt_d + c_CW'(1);

      busy_d       = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      stage_done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= ST_IDLE;
         len_cls_q    <= c_L128;
         is_ntt_q     <= 1'b0;
         issue_cnt_q  <= '0;
         wr_cnt_q     <= '0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         stage_done_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_a_q  <= '0;
         wr_addr_b_q  <= '0;
         wdata_a_q    <= '0;
         wdata_b_q    <= '0;
         for (int i = 0; i < BU_LAT; i++) begin
            tag_v_q[i] <= 1'b0;
            tag_a_q[i] <= '0;
            tag_b_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         len_cls_q    <= len_cls_d;
         is_ntt_q     <= is_ntt_d;
         issue_cnt_q  <= issue_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         stage_done_q <= stage_done_d;
         wr_en_q      <= wr_en_d;
         wr_addr_a_q  <= wr_addr_a_d;
         wr_addr_b_q  <= wr_addr_b_d;
         wdata_a_q    <= wdata_a_d;
         wdata_b_q    <= wdata_b_d;
         for (int i = 0; i < BU_LAT; i++) begin
            tag_v_q[i] <= tag_v_d[i];
            tag_a_q[i] <= tag_a_d[i];
            tag_b_q[i] <= tag_b_d[i];
         end
      end
   end

   assign wr_en_o      = wr_en_q;
   assign wr_addr_a_o  = wr_addr_a_q;
   assign wr_addr_b_o  = wr_addr_b_q;
   assign wdata_a_o    = wdata_a_q;
   assign wdata_b_o    = wdata_b_q;
   assign busy_o       = busy_q;
   assign stage_done_o = stage_done_q;
   assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bu_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_bu_writeback
// Description : Self-checking bench for bu_writeback: forward-routing model
//               plus directed scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bu_writeback;

   localparam int DW  = 13;
   localparam int AW  = 5;
   localparam int LAT = 3;
   localparam int G   = 16;
   localparam int W   = DW - 1;
   localparam int BW  = 8 * W;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          stage_start_i = 1'b0;
   logic [7:0]    len_i = 8'd0;
   logic          is_ntt_i = 1'b0;
   logic          issue_valid_i = 1'b0;
   logic [AW-1:0] issue_addr_a_i = '0;
   logic [AW-1:0] issue_addr_b_i = '0;
   logic [BW-1:0] a_ntt_i = '0, b_ntt_i = '0, a_intt_i = '0, b_intt_i = '0;
   logic          wr_en_o;
   logic [AW-1:0] wr_addr_a_o, wr_addr_b_o;
   logic [BW-1:0] wdata_a_o, wdata_b_o;
   logic          busy_o, stage_done_o, err_o;

   bu_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BU_LAT(LAT), .GROUPS(G)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .stage_start_i(stage_start_i), .len_i(len_i),
      .is_ntt_i(is_ntt_i), .issue_valid_i(issue_valid_i),
      .issue_addr_a_i(issue_addr_a_i), .issue_addr_b_i(issue_addr_b_i),
      .a_ntt_i(a_ntt_i), .b_ntt_i(b_ntt_i), .a_intt_i(a_intt_i), .b_intt_i(b_intt_i),
      .wr_en_o(wr_en_o), .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o),
      .wdata_a_o(wdata_a_o), .wdata_b_o(wdata_b_o), .busy_o(busy_o),
      .stage_done_o(stage_done_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int tests_run = 0;
   int tests_failed = 0;

   task automatic checki(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkv(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Forward routing as written in the stage tables: rt[class][bu][0=A out,1=B out]
   // gives destination code bank*2 + (port B ? 1 : 0).
   int rt [4][8][2];

   function automatic int cls_of(input logic [7:0] l);
      case (l)
         8'd128: return 0;
         8'd64:  return 1;
         8'd32:  return 2;
         8'd16, 8'd8, 8'd4, 8'd2: return 3;
         default: return -1;
      endcase
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct packed {
      int            due;
      logic [AW-1:0] a;
      logic [AW-1:0] b;
   } pend_t;

   pend_t         pq[$];
   int            m_edge = 0, m_phase = 0, m_issued = 0, m_written = 0, m_cls = 0;
   bit            m_ntt = 1'b0;
   logic          exp_wr_en = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
   logic [AW-1:0] exp_addr_a = '0, exp_addr_b = '0;
   logic [BW-1:0] exp_wd_a = '0, exp_wd_b = '0;

   initial forever begin
      pend_t         p;
      int            c;
      logic [W-1:0]  av, bv;
      @(posedge clk_i or negedge rst_i);
      if (!rst_i) begin
         pq.delete();
         m_phase = 0; m_issued = 0; m_written = 0;
         exp_wr_en = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
         exp_addr_a = '0; exp_addr_b = '0; exp_wd_a = '0; exp_wd_b = '0;
      end else begin
         m_edge++;
         case (m_phase)
            0: begin
               if (stage_start_i) begin
                  c = cls_of(len_i);
                  if (c >= 0) begin
                     m_cls = c; m_ntt = is_ntt_i; m_issued = 0; m_written = 0;
                     exp_err = 1'b0; m_phase = 1;
                  end else exp_err = 1'b1;
               end
               if (issue_valid_i) exp_err = 1'b1;
            end
            1: begin
               if (stage_start_i) exp_err = 1'b1;
               if (issue_valid_i) begin
                  pq.push_back('{due: m_edge + LAT, a: issue_addr_a_i, b: issue_addr_b_i});
                  m_issued++;
                  if (m_issued == G) m_phase = 2;
               end
            end
            2: begin
               if (stage_start_i || issue_valid_i) exp_err = 1'b1;
               if (m_written == G) m_phase = 3;
            end
            default: begin
               if (stage_start_i || issue_valid_i) exp_err = 1'b1;
               m_phase = 0;
            end
         endcase
         exp_wr_en = 1'b0;
         if (pq.size() > 0 && pq[0].due == m_edge) begin
            p = pq.pop_front();
            exp_wr_en = 1'b1;
            exp_addr_a = p.a;
            exp_addr_b = p.b;
            for (int k = 0; k < 8; k++) begin
               av = m_ntt ? a_ntt_i[k*W +: W] : a_intt_i[k*W +: W];
               bv = m_ntt ? b_ntt_i[k*W +: W] : b_intt_i[k*W +: W];
               for (int o = 0; o < 2; o++) begin
                  c = rt[m_cls][k][o];
                  if (c % 2 == 0) exp_wd_a[(c/2)*W +: W] = (o == 0) ? av : bv;
                  else            exp_wd_b[(c/2)*W +: W] = (o == 0) ? av : bv;
               end
            end
            m_written++;
         end
         exp_busy = (m_phase == 1) || (m_phase == 2);
         exp_done = (m_phase == 3);
      end
   end

   // ---------------- compare + monitor ----------------
   bit chk_en = 1'b0;
   int cyc = 0, wr_total = 0, first_wr = -1, last_wr = -1, done_cyc = -1, done_count = 0;

   initial forever begin
      @(negedge clk_i);
      cyc++;
      if (wr_en_o) begin
         if (wr_total == 0) first_wr = cyc;
         wr_total++;
         last_wr = cyc;
      end
      if (stage_done_o) begin
         done_count++;
         done_cyc = cyc;
      end
      if (chk_en) begin
         checki("wr_en", int'(wr_en_o), int'(exp_wr_en));
         if (exp_wr_en) begin
            checki("wr_addr_a", int'(wr_addr_a_o), int'(exp_addr_a));
            checki("wr_addr_b", int'(wr_addr_b_o), int'(exp_addr_b));
         end
         checkv("wdata_a", wdata_a_o, exp_wd_a);
         checkv("wdata_b", wdata_b_o, exp_wd_b);
         checki("busy", int'(busy_o), int'(exp_busy));
         checki("stage_done", int'(stage_done_o), int'(exp_done));
         checki("err", int'(err_o), int'(exp_err));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge clk_i);
      #1;
   endtask

   task automatic clear_mon();
      wr_total = 0; first_wr = -1; last_wr = -1; done_cyc = -1; done_count = 0;
   endtask

   task automatic randomize_bu();
      a_ntt_i  = {$urandom, $urandom, $urandom};
      b_ntt_i  = {$urandom, $urandom, $urandom};
      a_intt_i = {$urandom, $urandom, $urandom};
      b_intt_i = {$urandom, $urandom, $urandom};
   endtask

   task automatic start_stage(input logic [7:0] len, input logic ntt);
      stage_start_i = 1'b1;
      len_i = len;
      is_ntt_i = ntt;
      step();
      stage_start_i = 1'b0;
   endtask

   task automatic issue_burst(input int n, input int a0, input bit rnd);
      for (int i = 0; i < n; i++) begin
         issue_valid_i = 1'b1;
         issue_addr_a_i = AW'(a0 + i);
         issue_addr_b_i = AW'(a0 + i + 16);
         if (rnd) randomize_bu();
         step();
      end
      issue_valid_i = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!stage_done_o && n < 80) begin
         step();
         n++;
      end
      tests_run++;
      if (!stage_done_o) begin
         tests_failed++;
         $display("FAIL %s: stage_done never seen within %0d cycles", name, n);
      end
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      rt = '{
         '{'{0,8}, '{1,9}, '{2,10}, '{3,11}, '{4,12}, '{5,13}, '{6,14}, '{7,15}},
         '{'{0,2}, '{4,6}, '{1,3},  '{5,7},  '{8,10}, '{12,14},'{9,11}, '{13,15}},
         '{'{0,2}, '{1,3}, '{4,6},  '{5,7},  '{8,10}, '{9,11}, '{12,14},'{13,15}},
         '{'{0,1}, '{2,3}, '{4,6},  '{5,7},  '{8,10}, '{9,11}, '{12,14},'{13,15}}
      };
      repeat (3) step();
      checki("reset_wr_en", int'(wr_en_o), 0);
      checki("reset_busy", int'(busy_o), 0);
      checki("reset_done", int'(stage_done_o), 0);
      checki("reset_err", int'(err_o), 0);
      checkv("reset_wdata_a", wdata_a_o, '0);
      rst_i = 1'b1;
      chk_en = 1'b1;
      step();

      // len 128 NTT single issue, latency and routing literals
      for (int k = 0; k < 8; k++) begin
         a_ntt_i[k*W +: W]  = W'(k + 1);
         b_ntt_i[k*W +: W]  = W'(k + 16);
         a_intt_i[k*W +: W] = W'(12'hF00 + k);
         b_intt_i[k*W +: W] = W'(12'hE00 + k);
      end
      clear_mon();
      start_stage(8'd128, 1'b1);
      issue_valid_i = 1'b1; issue_addr_a_i = 5'd3; issue_addr_b_i = 5'd19;
      step();
      issue_valid_i = 1'b0;
      checki("lat_c1_wr_en", int'(wr_en_o), 0);
      step();
      checki("lat_c2_wr_en", int'(wr_en_o), 0);
      step();
      checki("lat_c3_wr_en", int'(wr_en_o), 0);
      step();
      checki("lat_c4_wr_en", int'(wr_en_o), 1);
      checki("l128_addr_a", int'(wr_addr_a_o), 3);
      checki("l128_addr_b", int'(wr_addr_b_o), 19);
      checki("l128_bank4A", int'(wdata_a_o[4*W +: W]), 'h10);
      checki("l128_bank7B", int'(wdata_b_o[7*W +: W]), 'h17);
      checki("l128_bank3B", int'(wdata_b_o[3*W +: W]), 8);
      issue_burst(15, 4, 1'b1);
      wait_done("l128_done");
      checki("l128_busy_at_done", int'(busy_o), 0);
      checki("l128_writes", wr_total, 16);

      // len 16 iNTT, 16 back-to-back issues with addresses 0..15
      step();
      randomize_bu();
      a_intt_i[1*W +: W] = 12'hABC;
      b_intt_i[1*W +: W] = 12'h123;
      clear_mon();
      start_stage(8'd16, 1'b0);
      issue_burst(16, 0, 1'b0);
      wait_done("l16_done");
      checki("l16_writes", wr_total, 16);
      checki("l16_consecutive", last_wr - first_wr, 15);
      checki("l16_done_after_last", done_cyc, last_wr + 1);
      checki("l16_busy_at_done", int'(busy_o), 0);
      checki("l16_bank1A", int'(wdata_a_o[1*W +: W]), 'hABC);
      checki("l16_bank1B", int'(wdata_b_o[1*W +: W]), 'h123);

      // len 64 with a 17th issue during DRAIN
      step();
      clear_mon();
      start_stage(8'd64, 1'b1);
      issue_burst(17, 8, 1'b1);
      wait_done("l64_done");
      checki("l64_writes", wr_total, 16);
      checki("l64_err", int'(err_o), 1);

      // back-to-back legal stage clears err (len 32, then len 2)
      step();
      clear_mon();
      start_stage(8'd32, 1'b0);
      checki("l32_err_cleared", int'(err_o), 0);
      issue_burst(16, 0, 1'b1);
      wait_done("l32_done");
      step();
      start_stage(8'd2, 1'b1);
      issue_burst(16, 5, 1'b1);
      wait_done("l2_done");
      checki("l32_l2_writes", wr_total, 32);

      // illegal length
      step();
      start_stage(8'd100, 1'b1);
      checki("bad_len_err", int'(err_o), 1);
      checki("bad_len_busy", int'(busy_o), 0);
      clear_mon();
      issue_burst(4, 0, 1'b1);
      repeat (6) step();
      checki("bad_len_writes", wr_total, 0);

      // reset mid-DRAIN with two groups in flight
      start_stage(8'd128, 1'b1);
      issue_burst(16, 0, 1'b1);
      step();
      rst_i = 1'b0;
      clear_mon();
      repeat (2) step();
      rst_i = 1'b1;
      repeat (20) step();
      checki("rst_drain_writes", wr_total, 0);
      checki("rst_drain_done", done_count, 0);
      checki("rst_drain_busy", int'(busy_o), 0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
`default_nettype wire
